// File: rtl/tempsense_sar_ctrl_if.sv
// Signal bundle between the temperature-sensor conversion controller and its
// environment (requester side plus the VDAC / delay-cell analog front end).
interface tempsense_sar_ctrl_if #(
    parameter int unsigned N_DAC = 7
);
    logic             start;
    logic             mode;
    logic             tempdelay;
    logic [N_DAC-1:0] dac_data;
    logic             dac_en;
    logic             precharge_n;
    logic             busy;
    logic [N_DAC-1:0] result;
    logic             result_valid;
    logic             nohit;

    modport master (
        output start, mode, tempdelay,
        input  dac_data, dac_en, precharge_n, busy, result, result_valid, nohit
    );

    modport slave (
        input  start, mode, tempdelay,
        output dac_data, dac_en, precharge_n, busy, result, result_valid, nohit
    );
endinterface

// File: rtl/tempsense_sar_ctrl.sv
// Delay-cell temperature sensor controller: drives the VDAC through precharge /
// transition / measure trials, using a linear down-sweep or SAR search, with optional averaging.
module tempsense_sar_ctrl #(
    parameter int unsigned N_DAC = 7,
    parameter int unsigned N_AVG = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    tempsense_sar_ctrl_if.slave  bus
);
    localparam int unsigned ACC_W     = N_DAC + N_AVG;
    localparam int unsigned CNT_W     = (N_AVG > 0) ? N_AVG : 1;
    localparam int unsigned MEAS_LAST = (1 << N_AVG) - 1;
    localparam logic [N_DAC-1:0] ONES = {N_DAC{1'b1}};
    localparam logic [N_DAC-1:0] MSB  = {1'b1, {(N_DAC-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_TRANSITION,
        S_MEASURE,
        S_EVALUATE,
        S_DONE
    } state_t;

    state_t           state;
    logic             mode_q;
    logic [N_DAC-1:0] sweep_code;
    logic [N_DAC-1:0] sar_kept;
    logic [N_DAC-1:0] sar_bit;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             any_hit;

    logic [N_DAC-1:0] trial_code;
    logic [N_DAC-1:0] sar_kept_nx;
    logic [N_DAC-1:0] meas_value;
    logic             meas_done;
    logic             meas_hit;
    logic [ACC_W-1:0] acc_sum;

    // Trial code and end-of-measurement decode; tempdelay only matters in EVALUATE.
    always_comb begin
        sar_kept_nx = bus.tempdelay ? (sar_kept | sar_bit) : sar_kept;
        trial_code  = mode_q ? (sar_kept | sar_bit) : sweep_code;
        if (mode_q) begin
            meas_done  = sar_bit[0];
            meas_value = sar_kept_nx;
            meas_hit   = |sar_kept_nx;
        end else begin
            meas_done  = bus.tempdelay || (sweep_code == '0);
            meas_value = bus.tempdelay ? sweep_code : '0;
            meas_hit   = bus.tempdelay;
        end
        acc_sum = acc + ACC_W'(meas_value);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            mode_q           <= 1'b0;
            sweep_code       <= ONES;
            sar_kept         <= '0;
            sar_bit          <= MSB;
            acc              <= '0;
            cnt              <= '0;
            any_hit          <= 1'b0;
            bus.dac_data     <= ONES;
            bus.dac_en       <= 1'b0;
            bus.precharge_n  <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.nohit        <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q     <= bus.mode;
                        sweep_code <= ONES;
                        sar_kept   <= '0;
                        sar_bit    <= MSB;
                        acc        <= '0;
                        cnt        <= '0;
                        any_hit    <= 1'b0;
                        bus.dac_en <= 1'b1;
                        bus.busy   <= 1'b1;
                        state      <= S_PRECHARGE;
                    end
                end
                S_PRECHARGE: begin
                    bus.dac_data    <= '0;
                    bus.precharge_n <= 1'b1;
                    state           <= S_TRANSITION;
                end
                S_TRANSITION: begin
                    bus.dac_data <= trial_code;
                    state        <= S_MEASURE;
                end
                S_MEASURE: begin
                    state <= S_EVALUATE;
                end
                S_EVALUATE: begin
                    bus.dac_data    <= ONES;
                    bus.precharge_n <= 1'b0;
                    if (!meas_done) begin
                        // Advance the search within the current measurement.
                        if (mode_q) begin
                            sar_kept <= sar_kept_nx;
                            sar_bit  <= sar_bit >> 1;
                        end else begin
                            sweep_code <= sweep_code - N_DAC'(1);
                        end
                        state <= S_PRECHARGE;
                    end else begin
                        acc        <= acc_sum;
                        any_hit    <= any_hit | meas_hit;
                        sweep_code <= ONES;
                        sar_kept   <= '0;
                        sar_bit    <= MSB;
                        if (cnt == CNT_W'(MEAS_LAST)) begin
                            bus.dac_en       <= 1'b0;
                            bus.result       <= N_DAC'(acc_sum >> N_AVG);
                            bus.result_valid <= 1'b1;
                            bus.nohit        <= ~(any_hit | meas_hit);
                            state            <= S_DONE;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= S_PRECHARGE;
                        end
                    end
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tempsense_sar_ctrl.sv
// Directed bench for tempsense_sar_ctrl: a threshold delay-cell model, with expected
// results queued at start and checked against each result_valid pulse.
module tb_tempsense_sar_ctrl;
    localparam int unsigned N_DAC = 7;

    typedef struct {
        int res;
        int nh;
        int cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0 = -1;
    int   t1 = -1;
    exp_t sb0[$];
    exp_t sb1[$];

    tempsense_sar_ctrl_if #(.N_DAC(N_DAC)) bus0 ();
    tempsense_sar_ctrl_if #(.N_DAC(N_DAC)) bus1 ();

    tempsense_sar_ctrl #(.N_DAC(N_DAC), .N_AVG(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    tempsense_sar_ctrl #(.N_DAC(N_DAC), .N_AVG(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Delay-cell model: hit when the applied code is at or below the threshold.
    assign bus0.tempdelay = bus0.precharge_n & bus0.dac_en & (int'(bus0.dac_data) <= t0);
    assign bus1.tempdelay = bus1.precharge_n & bus1.dac_en & (int'(bus1.dac_data) <= t1);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every result_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus0.result_valid) begin
            check("d0_valid_expected", 32'(sb0.size() != 0), 1);
            if (sb0.size() != 0) begin
                exp_t e;
                e = sb0.pop_front();
                check("d0_result", bus0.result, e.res);
                check("d0_nohit", bus0.nohit, e.nh);
                check("d0_done_cycle", cyc, e.cyc);
            end
        end
        if (bus1.result_valid) begin
            check("d1_valid_expected", 32'(sb1.size() != 0), 1);
            if (sb1.size() != 0) begin
                exp_t e;
                e = sb1.pop_front();
                check("d1_result", bus1.result, e.res);
                check("d1_nohit", bus1.nohit, e.nh);
                check("d1_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_rst0(input string p);
        check({p, "_result"}, bus0.result, 0);
        check({p, "_result_valid"}, bus0.result_valid, 0);
        check({p, "_nohit"}, bus0.nohit, 0);
        check({p, "_busy"}, bus0.busy, 0);
        check({p, "_dac_en"}, bus0.dac_en, 0);
        check({p, "_dac_data"}, bus0.dac_data, 127);
        check({p, "_precharge_n"}, bus0.precharge_n, 0);
    endtask

    // One dut0 conversion; also flips mode and pulses start while busy and in DONE.
    task automatic run0(input bit m, input int t, input int res, input int nh, input int lat,
                        input bit detail);
        int nb;
        nb = 0;
        bus0.mode  = m;
        t0         = t;
        bus0.start = 1'b1;
        sb0.push_back('{res, nh, cyc + lat});
        for (int i = 1; i <= lat + 8; i++) begin
            tick();
            bus0.start = (i == 10) || (i == lat);
            if (i == 5) bus0.mode = ~m;
            if (bus0.busy) nb++;
            if (detail && i == 1) begin
                check("pre_dac_data", bus0.dac_data, 127);
                check("pre_precharge_n", bus0.precharge_n, 0);
                check("pre_dac_en", bus0.dac_en, 1);
            end
            if (detail && i == 2) begin
                check("trans_dac_data", bus0.dac_data, 0);
                check("trans_precharge_n", bus0.precharge_n, 1);
            end
            if (detail && (i == 3 || i == 4)) begin
                check("meas_dac_data", bus0.dac_data, 64);
                check("meas_precharge_n", bus0.precharge_n, 1);
            end
            if (i == lat) begin
                check("done_dac_en", bus0.dac_en, 0);
                check("done_dac_data", bus0.dac_data, 127);
                check("done_precharge_n", bus0.precharge_n, 0);
            end
            if (!bus0.busy && sb0.size() == 0) break;
        end
        check("d0_busy_cycles", nb, lat);
        check("d0_drained", sb0.size(), 0);
        check("d0_result_held", bus0.result, res);
    endtask

    // One dut1 (4-measurement average) SAR conversion with a threshold per measurement.
    task automatic run1(input int ta, input int tb, input int tc, input int td,
                        input int res, input int nh);
        bus1.mode  = 1'b1;
        t1         = ta;
        bus1.start = 1'b1;
        sb1.push_back('{res, nh, cyc + 113});
        tick();
        bus1.start = 1'b0;
        tick(28); t1 = tb;
        tick(28); t1 = tc;
        tick(28); t1 = td;
        drain(60);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || bus0.busy || bus1.busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_time", 32'(n < budget), 1);
    endtask

    initial begin
        int c;
        reset      = 1'b1;
        bus0.start = 1'b0;
        bus0.mode  = 1'b0;
        bus1.start = 1'b0;
        bus1.mode  = 1'b0;
        tick(3);
        check_rst0("rst");
        check("rst_d1_busy", bus1.busy, 0);
        check("rst_d1_dac_data", bus1.dac_data, 127);
        reset = 1'b0;
        tick(2);

        // SAR and sweep, nominal and boundary thresholds
        run0(1'b1, 45, 45, 0, 29, 1'b1);
        run0(1'b0, 120, 120, 0, 33, 1'b0);
        run0(1'b0, -1, 0, 1, 513, 1'b0);
        run0(1'b1, -1, 0, 1, 29, 1'b0);
        run0(1'b0, 127, 127, 0, 5, 1'b0);
        run0(1'b1, 127, 127, 0, 29, 1'b0);
        run0(1'b1, 0, 0, 1, 29, 1'b0);
        run0(1'b0, 0, 0, 0, 513, 1'b0);
        run0(1'b1, 1, 1, 0, 29, 1'b0);

        // Abort in MEASURE of trial 3
        bus0.mode  = 1'b1;
        t0         = 45;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        tick(10);
        check("abort_trial3_code", bus0.dac_data, 48);
        check("abort_trial3_busy", bus0.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_rst0("abort");
        tick(40);
        check("abort_stays_idle", bus0.busy, 0);

        // Reset wins over start at the same edge
        reset      = 1'b1;
        bus0.start = 1'b1;
        tick();
        reset      = 1'b0;
        bus0.start = 1'b0;
        check("rst_over_start_busy", bus0.busy, 0);
        tick(2);
        check("rst_over_start_idle", bus0.busy, 0);

        run0(1'b1, 45, 45, 0, 29, 1'b0);

        // Start held high: back-to-back conversions every 30 cycles
        c          = cyc;
        bus0.mode  = 1'b1;
        t0         = 45;
        bus0.start = 1'b1;
        sb0.push_back('{45, 0, c + 29});
        sb0.push_back('{45, 0, c + 59});
        sb0.push_back('{45, 0, c + 89});
        for (int i = 1; i <= 61; i++) begin
            tick();
            if (i == 5) bus0.mode = 1'b0;
            if (i == 20) bus0.mode = 1'b1;
            if (i == 61) bus0.start = 1'b0;
        end
        drain(60);
        check("held_start_busy_end", bus0.busy, 0);
        check("held_start_drained", sb0.size(), 0);

        // Averaging over four SAR measurements
        run1(40, 41, 40, 41, 40, 0);
        run1(-1, -1, -1, -1, 0, 1);
        run1(-1, -1, -1, 41, 10, 0);
        run1(127, 127, 127, 126, 126, 0);
        check("d1_result_held", bus1.result, 126);

        tick(3);
        check("final_sb_empty", 32'(sb0.size() + sb1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tempsense_sar_ctrl.md
TEMPSENSE_SAR_CTRL -- requirements
Module: tempsense_sar_ctrl

Interface
REQ-001 Parameter N_DAC, default 7: VDAC code width; legal range 3..10.
REQ-002 Parameter N_AVG, default 0: log2 of measurements averaged per conversion; legal range 0..4.
REQ-003 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: conversion request; honoured only in IDLE.
REQ-006 Port mode, input, 1: 0 = linear down-sweep, 1 = successive approximation (SAR); captured with start.
REQ-007 Port tempdelay, input, 1: delay-cell output; 1 = hit at the current trial code.
REQ-008 Port dac_data, output, N_DAC: VDAC code driven to the delay cell.
REQ-009 Port dac_en, output, 1: VDAC enable.
REQ-010 Port precharge_n, output, 1: 0 = precharge the cell, 1 = release it for measurement.
REQ-011 Port busy, output, 1: high from the cycle after start is accepted until the DONE cycle, inclusive.
REQ-012 Port result, output, N_DAC: last conversion result, held between conversions.
REQ-013 Port result_valid, output, 1: one-cycle pulse when result updates.
REQ-014 Port nohit, output, 1: set with result_valid when no trial of the conversion produced a hit.

Function
REQ-015 States: IDLE, PRECHARGE, TRANSITION, MEASURE, EVALUATE, DONE; one cycle each, except IDLE.
REQ-016 IDLE: if start=1, latch mode, clear the accumulator and trial state, and enter PRECHARGE next cycle; otherwise stay in IDLE.
REQ-017 A trial is PRECHARGE -> TRANSITION -> MEASURE -> EVALUATE (4 cycles).
REQ-018 Outputs per state:
- PRECHARGE: dac_data = all ones, precharge_n = 0.
- TRANSITION: dac_data = 0, precharge_n = 1.
- MEASURE and EVALUATE: dac_data = trial code, precharge_n = 1.
- IDLE and DONE: dac_data = all ones, precharge_n = 0, dac_en = 0.
- dac_en = 1 in all other states.
REQ-019 tempdelay is sampled only on the clock edge that ends EVALUATE and is ignored in every other state.
REQ-020 Sweep mode:
- Trial codes run 2^N_DAC-1, 2^N_DAC-2, ..., 0.
- The first hit ends the measurement with value = that code.
- If code 0 gives no hit, the value is 0 and the measurement counts as a miss.
REQ-021 SAR mode:
- Bit N_DAC-1 down to bit 0: trial code = kept bits | tested bit.
- On a hit the tested bit is kept; otherwise it is cleared.
- Always N_DAC trials; value = the kept bits.
- The measurement is a miss when the value is 0 and the trial at code 1 gave no hit.
REQ-022 After each measurement, the value is added to an (N_DAC+N_AVG)-bit accumulator.
REQ-023 If fewer than 2^N_AVG measurements are done, the next trial begins at PRECHARGE; otherwise the state goes to DONE.
REQ-024 DONE cycle:
- result = accumulator >> N_AVG (truncating).
- result_valid = 1.
- nohit = 1 only if every measurement was a miss.
- The next state is IDLE.
REQ-025 Latency (start-accept cycle = 0):
- SAR: DONE at cycle 4*N_DAC*2^N_AVG + 1.
- Sweep with an immediate hit: DONE at cycle 4*2^N_AVG + 1.
- Worst-case sweep: DONE at cycle 4*2^N_DAC*2^N_AVG + 1.
REQ-026 start while busy is ignored, and mode changes while busy are ignored.
REQ-027 start in the DONE cycle is ignored; start in the following IDLE cycle is accepted, giving back-to-back conversions with one idle cycle.
REQ-028 result and nohit change only in DONE; result_valid is 0 in every other cycle.

Reset
REQ-029 When reset=1 at a clock edge, the next state is IDLE and any conversion in progress is aborted, with no result_valid pulse.
REQ-030 Reset values: result = 0, result_valid = 0, nohit = 0, busy = 0, dac_en = 0, dac_data = all ones, precharge_n = 0, accumulator = 0.
REQ-031 reset has priority over start at the same edge.

Verification
Bench model for all scenarios: tempdelay = (dac_data <= T) while in MEASURE or EVALUATE, and 0 otherwise.
REQ-032 N_DAC=7, N_AVG=0, mode=1, T=45, start pulse -> busy for 29 cycles, result=45 with result_valid at cycle 29, nohit=0.
REQ-033 N_DAC=7, N_AVG=0, mode=0, T=120 -> hit at the 8th trial, DONE at cycle 33, result=120.
REQ-034 mode=0 and mode=1 with T=-1 (tempdelay never 1) -> result=0, nohit=1; sweep DONE at cycle 513.
REQ-035 N_AVG=2, SAR, T toggling 40/41/40/41 per measurement -> accumulator 162, result=40, DONE at cycle 113.
REQ-036 reset asserted in MEASURE of trial 3 -> next cycle IDLE with all REQ-030 values and no result_valid; a fresh start then converts normally.
REQ-037 start held high continuously -> conversions repeat every (latency+1) cycles; start pulses during busy and in DONE cause no extra conversion.
